// File: rtl/zeroriscy_defines.sv
// zeroriscy_defines: shared encodings for the iterative multiply/divide unit.
// Holds the operator encodings, the FSM state enum, the iteration count and
// a small helper that forms the adder operand used for two's-complement negation.
package zeroriscy_defines;

   typedef enum logic [1:0] {
      MD_OP_MULL = 2'd0,
      MD_OP_MULH = 2'd1,
      MD_OP_DIV  = 2'd2,
      MD_OP_REM  = 2'd3
   } md_op_e;

   typedef enum logic [2:0] {
      MD_IDLE   = 3'd0,
      MD_ABS_A  = 3'd1,
      MD_ABS_B  = 3'd2,
      MD_COMP   = 3'd3,
      MD_NEG_LO = 3'd4,
      MD_NEG_HI = 3'd5,
      MD_FINISH = 3'd6
   } md_state_e;

   localparam int unsigned MD_ITER = 32;

   // {~x,1} paired with {0,1} makes the shared adder produce ~x + 1 = -x.
   function automatic logic [32:0] md_neg_operand(input logic [31:0] x);
      return {~x, 1'b1};
   endfunction

endpackage

// File: rtl/zeroriscy_multdiv_iter.sv
// zeroriscy_multdiv_iter: iterative radix-2 RV32M multiply/divide unit.
// Borrows the ALU's 33-bit adder (bit0 is a carry-injection slot) and returns
// a registered 32-bit result with a one-cycle ready_o pulse.
// Optional macro ZERORISCY_MD_EARLY_EN: skip sign-fix states that would only
// hold, giving a 33..37 cycle latency instead of a fixed 37.
module zeroriscy_multdiv_iter
   import zeroriscy_defines::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        mult_en_i,
   input  logic        div_en_i,
   input  logic [1:0]  operator_i,
   input  logic [1:0]  signed_mode_i,
   input  logic [31:0] op_a_i,
   input  logic [31:0] op_b_i,
   input  logic [33:0] alu_adder_ext_i,
   output logic [32:0] alu_operand_a_o,
   output logic [32:0] alu_operand_b_o,
   output logic        alu_en_o,
   output logic [31:0] multdiv_result_o,
   output logic        ready_o
);

   md_state_e   r_state, w_state_nxt;
   logic [5:0]  r_cnt, w_cnt_nxt;
   logic [31:0] r_a, w_a_nxt;        // |a| once ABS_A has run
   logic [31:0] r_b, w_b_nxt;        // |b| once ABS_B has run
   logic [31:0] r_hi, w_hi_nxt;      // acc_hi (multiply) / remainder (divide)
   logic [31:0] r_lo, w_lo_nxt;      // acc_lo (multiply) / quotient (divide)
   logic        r_c, w_c_nxt;        // carry out of the low-word negation
   md_op_e      r_op, w_op_nxt;
   logic        r_mul, w_mul_nxt;
   logic        r_a_neg, w_a_neg_nxt;
   logic        r_b_neg, w_b_neg_nxt;
   logic        r_neg, w_neg_nxt;    // final result needs negation

   logic [32:0] r_alu_a, w_alu_a_nxt;
   logic [32:0] r_alu_b, w_alu_b_nxt;
   logic        r_alu_en, w_alu_en_nxt;
   logic [31:0] r_result, w_result_nxt;
   logic        r_ready, w_ready_nxt;

   logic [32:0] w_res;
   logic        w_en;
   logic        w_lo_is_hi;          // REM keeps its low-word fix-up in r_hi
   logic        w_sel_hi;            // result word comes from r_hi
   logic        w_neg_hi;            // MULH needs the upper-word fix-up
   logic        w_an, w_bn;
   logic        w_unused;

   assign w_res      = alu_adder_ext_i[33:1];
   assign w_unused   = alu_adder_ext_i[0];
   assign w_en       = mult_en_i | div_en_i;
   assign w_lo_is_hi = !r_mul && (r_op == MD_OP_REM);
   assign w_sel_hi   = r_mul ? (r_op != MD_OP_MULL) : (r_op == MD_OP_REM);
   assign w_neg_hi   = r_neg && r_mul && (r_op != MD_OP_MULL);
   assign w_an       = signed_mode_i[0] & op_a_i[31];
   assign w_bn       = signed_mode_i[1] & op_b_i[31];

   // Next-state and datapath update for the FSM.
   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_a_nxt     = r_a;
      w_b_nxt     = r_b;
      w_hi_nxt    = r_hi;
      w_lo_nxt    = r_lo;
      w_c_nxt     = r_c;
      w_op_nxt    = r_op;
      w_mul_nxt   = r_mul;
      w_a_neg_nxt = r_a_neg;
      w_b_neg_nxt = r_b_neg;
      w_neg_nxt   = r_neg;
      case (r_state)
         MD_IDLE: begin
            if (w_en) begin
               w_a_nxt     = op_a_i;
               w_b_nxt     = op_b_i;
               w_op_nxt    = md_op_e'(operator_i);
               w_mul_nxt   = mult_en_i;
               w_a_neg_nxt = w_an;
               w_b_neg_nxt = w_bn;
               if (mult_en_i) begin
                  w_neg_nxt = w_an ^ w_bn;
               end else if (operator_i == MD_OP_REM) begin
                  w_neg_nxt = w_an;
               end else begin
                  w_neg_nxt = (w_an ^ w_bn) & (op_b_i != 32'd0);
               end
               w_hi_nxt = 32'd0;
               w_lo_nxt = mult_en_i ? op_b_i : op_a_i;
               w_cnt_nxt = 6'd0;
               w_c_nxt   = 1'b0;
`ifdef ZERORISCY_MD_EARLY_EN
               w_state_nxt = w_an ? MD_ABS_A : (w_bn ? MD_ABS_B : MD_COMP);
`else
               w_state_nxt = MD_ABS_A;
`endif
            end else begin
               w_state_nxt = MD_IDLE;
            end
         end
         MD_ABS_A: begin
            if (!w_en) begin
               w_state_nxt = MD_IDLE;
            end else begin
               if (r_a_neg) begin
                  w_a_nxt = w_res[31:0];
                  w_lo_nxt = r_mul ? r_lo : w_res[31:0];
               end else begin
                  w_a_nxt = r_a;
               end
`ifdef ZERORISCY_MD_EARLY_EN
               w_state_nxt = r_b_neg ? MD_ABS_B : MD_COMP;
`else
               w_state_nxt = MD_ABS_B;
`endif
            end
         end
         MD_ABS_B: begin
            if (!w_en) begin
               w_state_nxt = MD_IDLE;
            end else begin
               if (r_b_neg) begin
                  w_b_nxt = w_res[31:0];
                  w_lo_nxt = r_mul ? w_res[31:0] : r_lo;
               end else begin
                  w_b_nxt = r_b;
               end
               w_state_nxt = MD_COMP;
            end
         end
         MD_COMP: begin
            if (!w_en) begin
               w_state_nxt = MD_IDLE;
            end else begin
               if (r_mul) begin
                  // Shift {carry, sum, acc_lo} right by one.
                  w_hi_nxt = w_res[32:1];
                  w_lo_nxt = {w_res[0], r_lo[31:1]};
               end else if (w_res[32] || r_hi[31]) begin
                  // Trial subtraction fits: keep the difference, shift in 1.
                  w_hi_nxt = w_res[31:0];
                  w_lo_nxt = {r_lo[30:0], 1'b1};
               end else begin
                  w_hi_nxt = {r_hi[30:0], r_lo[31]};
                  w_lo_nxt = {r_lo[30:0], 1'b0};
               end
               if (r_cnt == 6'(MD_ITER - 1)) begin
                  w_cnt_nxt = 6'd0;
`ifdef ZERORISCY_MD_EARLY_EN
                  w_state_nxt = r_neg ? MD_NEG_LO : MD_FINISH;
`else
                  w_state_nxt = MD_NEG_LO;
`endif
               end else begin
                  w_cnt_nxt = r_cnt + 6'd1;
               end
            end
         end
         MD_NEG_LO: begin
            if (!w_en) begin
               w_state_nxt = MD_IDLE;
            end else begin
               if (r_neg) begin
                  w_c_nxt = w_res[32];
                  if (w_lo_is_hi) begin
                     w_hi_nxt = w_res[31:0];
                  end else begin
                     w_lo_nxt = w_res[31:0];
                  end
               end else begin
                  w_c_nxt = r_c;
               end
`ifdef ZERORISCY_MD_EARLY_EN
               w_state_nxt = w_neg_hi ? MD_NEG_HI : MD_FINISH;
`else
               w_state_nxt = MD_NEG_HI;
`endif
            end
         end
         MD_NEG_HI: begin
            if (!w_en) begin
               w_state_nxt = MD_IDLE;
            end else begin
               if (w_neg_hi) begin
                  w_hi_nxt = w_res[31:0];
               end else begin
                  w_hi_nxt = r_hi;
               end
               w_state_nxt = MD_FINISH;
            end
         end
         MD_FINISH: begin
            w_state_nxt = MD_IDLE;
         end
         default: begin
            w_state_nxt = MD_IDLE;
         end
      endcase
   end

   // Adder operands, enable and result for the cycle the FSM enters next.
   always_comb begin
      w_alu_a_nxt  = 33'd0;
      w_alu_b_nxt  = 33'd0;
      w_alu_en_nxt = 1'b0;
      w_ready_nxt  = 1'b0;
      w_result_nxt = r_result;
      case (w_state_nxt)
         MD_ABS_A: begin
            w_alu_en_nxt = 1'b1;
            w_alu_a_nxt  = 33'd1;
            w_alu_b_nxt  = md_neg_operand(w_a_nxt);
         end
         MD_ABS_B: begin
            w_alu_en_nxt = 1'b1;
            w_alu_a_nxt  = 33'd1;
            w_alu_b_nxt  = md_neg_operand(w_b_nxt);
         end
         MD_COMP: begin
            w_alu_en_nxt = 1'b1;
            if (w_mul_nxt) begin
               w_alu_a_nxt = {w_hi_nxt, 1'b0};
               w_alu_b_nxt = {(w_lo_nxt[0] ? w_a_nxt : 32'd0), 1'b0};
            end else begin
               w_alu_a_nxt = {w_hi_nxt[30:0], w_lo_nxt[31], 1'b1};
               w_alu_b_nxt = {~w_b_nxt, 1'b1};
            end
         end
         MD_NEG_LO: begin
            w_alu_en_nxt = 1'b1;
            w_alu_a_nxt  = 33'd1;
            w_alu_b_nxt  = md_neg_operand(w_lo_is_hi ? w_hi_nxt : w_lo_nxt);
         end
         MD_NEG_HI: begin
            w_alu_en_nxt = 1'b1;
            w_alu_a_nxt  = {~w_hi_nxt, w_c_nxt};
            w_alu_b_nxt  = {32'd0, w_c_nxt};
         end
         MD_FINISH: begin
            w_ready_nxt  = 1'b1;
            w_result_nxt = w_sel_hi ? w_hi_nxt : w_lo_nxt;
         end
         default: begin
            w_alu_en_nxt = 1'b0;
         end
      endcase
   end

   // State, datapath and output registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state  <= MD_IDLE;
         r_cnt    <= 6'd0;
         r_a      <= 32'd0;
         r_b      <= 32'd0;
         r_hi     <= 32'd0;
         r_lo     <= 32'd0;
         r_c      <= 1'b0;
         r_op     <= MD_OP_MULL;
         r_mul    <= 1'b0;
         r_a_neg  <= 1'b0;
         r_b_neg  <= 1'b0;
         r_neg    <= 1'b0;
         r_alu_a  <= 33'd0;
         r_alu_b  <= 33'd0;
         r_alu_en <= 1'b0;
         r_result <= 32'd0;
         r_ready  <= 1'b0;
      end else begin
         r_state  <= w_state_nxt;
         r_cnt    <= w_cnt_nxt;
         r_a      <= w_a_nxt;
         r_b      <= w_b_nxt;
         r_hi     <= w_hi_nxt;
         r_lo     <= w_lo_nxt;
         r_c      <= w_c_nxt;
         r_op     <= w_op_nxt;
         r_mul    <= w_mul_nxt;
         r_a_neg  <= w_a_neg_nxt;
         r_b_neg  <= w_b_neg_nxt;
         r_neg    <= w_neg_nxt;
         r_alu_a  <= w_alu_a_nxt;
         r_alu_b  <= w_alu_b_nxt;
         r_alu_en <= w_alu_en_nxt;
         r_result <= w_result_nxt;
         r_ready  <= w_ready_nxt;
      end
   end

   assign alu_operand_a_o  = r_alu_a;
   assign alu_operand_b_o  = r_alu_b;
   assign alu_en_o         = r_alu_en;
   assign multdiv_result_o = r_result;
   assign ready_o          = r_ready;

endmodule
